// File: rtl/wvb_rd_pkg.sv
// Shared types and constants for the waveform buffer readout sequencer.
// Used by wvb_readout_ctrl and wvb_rd_skid.
package wvb_rd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HDR_WAIT,
      STREAM,
      DONE
   } state_t;

   localparam int HDR_START_LSB = 0;
   localparam int SKID_DEPTH    = 2;

   // Stop address sits directly above the start address field.
   function automatic int hdr_stop_lsb(input int adr_w);
      return HDR_START_LSB + adr_w;
   endfunction

endpackage

// File: rtl/wvb_rd_skid.sv
// Two-entry valid/ready skid FIFO carrying {last, data}.
// Empty FIFO passes input straight to the output in the same cycle.
module wvb_rd_skid
   import wvb_rd_pkg::*;
#(
   parameter int W = 23
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic [1:0]   count
);

   logic [W-1:0] mem [SKID_DEPTH];
   logic         wp;
   logic         rp;
   logic         push;
   logic         pop;
   logic         empty;

   assign empty     = (count == 2'd0);
   assign out_valid = !empty || in_valid;
   assign pop       = !empty && out_ready;
   assign push      = in_valid && !(empty && out_ready);

   always_comb begin
      out_data = '0;
      if (!empty)
         out_data = mem[rp];
      else if (in_valid)
         out_data = in_data;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wp] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= 1'b0;
         rp    <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push)
            wp <= ~wp;
         if (pop)
            rp <= ~rp;
         count <= count + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/wvb_readout_ctrl.sv
// Waveform buffer readout sequencer: header pop, buffer walk, sample stream.
// Optional eoe consistency check enabled by defining WVB_RD_EOE_CHECK_EN.
module wvb_readout_ctrl
   import wvb_rd_pkg::*;
#(
   parameter int P_DATA_WIDTH = 22,
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_HDR_WIDTH  = 80
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    hdr_empty,
   input  logic [P_HDR_WIDTH-1:0]  hdr_data,
   output logic                    hdr_rdreq,
   output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
   input  logic [P_DATA_WIDTH-1:0] wvb_data,
   output logic [P_HDR_WIDTH-1:0]  hdr_out,
   output logic [P_DATA_WIDTH-1:0] dout,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    dout_last,
   output logic                    busy,
   output logic                    done,
   output logic [P_ADR_WIDTH-1:0]  rel_addr,
   output logic                    eoe_err
);

   localparam int STOP_LSB = hdr_stop_lsb(P_ADR_WIDTH);

   state_t                   state;
   logic [P_ADR_WIDTH-1:0]   rd_ptr;
   logic [P_ADR_WIDTH-1:0]   stop_r;
   logic                     final_issued;
   logic                     inflight;
   logic                     inflight_last;
   logic [1:0]               skid_count;
   logic [1:0]               occ;
   logic                     issue;
   logic                     accept;
   logic [P_DATA_WIDTH:0]    skid_out;

   // A read is only issued when its data is guaranteed a skid slot.
   assign occ    = skid_count + {1'b0, inflight};
   assign issue  = (state == STREAM) && !final_issued &&
                   (occ < 2'(SKID_DEPTH));
   assign accept = dout_valid && dout_ready;

   assign wvb_rd_addr         = rd_ptr;
   assign {dout_last, dout}   = skid_out;

   wvb_rd_skid #(
      .W (P_DATA_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inflight),
      .in_data   ({inflight_last, wvb_data}),
      .out_valid (dout_valid),
      .out_data  (skid_out),
      .out_ready (dout_ready),
      .count     (skid_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         hdr_rdreq     <= 1'b0;
         hdr_out       <= '0;
         rd_ptr        <= '0;
         stop_r        <= '0;
         final_issued  <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         rel_addr      <= '0;
      end else begin
         hdr_rdreq     <= 1'b0;
         done          <= 1'b0;
         inflight      <= issue;
         inflight_last <= issue && (rd_ptr == stop_r);
         if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == stop_r)
               final_issued <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (en && !hdr_empty) begin
                  hdr_rdreq <= 1'b1;
                  busy      <= 1'b1;
                  state     <= HDR_WAIT;
               end
            end
            HDR_WAIT: begin
               // Header FIFO data is valid the cycle after the pop.
               if (!hdr_rdreq) begin
                  hdr_out      <= hdr_data;
                  rd_ptr       <= hdr_data[HDR_START_LSB +: P_ADR_WIDTH];
                  stop_r       <= hdr_data[STOP_LSB +: P_ADR_WIDTH];
                  final_issued <= 1'b0;
                  state        <= STREAM;
               end
            end
            STREAM: begin
               if (accept && dout_last) begin
                  done     <= 1'b1;
                  rel_addr <= stop_r + 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (en && !hdr_empty) begin
                  hdr_rdreq <= 1'b1;
                  state     <= HDR_WAIT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WVB_RD_EOE_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         eoe_err <= 1'b0;
      else if (accept && (dout[0] != dout_last))
         eoe_err <= 1'b1;
   end
`else
   assign eoe_err = 1'b0;
`endif

endmodule

// File: tb/tb_wvb_readout_ctrl.sv
// Self-checking bench for wvb_readout_ctrl with header FIFO and buffer models.
// Sample stream checked through a scoreboard queue.
module tb_wvb_readout_ctrl;

   localparam int DW = 22;
   localparam int AW = 12;
   localparam int HW = 80;
`ifdef WVB_RD_EOE_CHECK_EN
   localparam bit EOE_ON = 1'b1;
`else
   localparam bit EOE_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          hdr_empty;
   logic [HW-1:0] hdr_data = '0;
   logic          hdr_rdreq;
   logic [AW-1:0] wvb_rd_addr;
   logic [DW-1:0] wvb_data = '0;
   logic [HW-1:0] hdr_out;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready = 1'b1;
   logic          dout_last;
   logic          busy;
   logic          done;
   logic [AW-1:0] rel_addr;
   logic          eoe_err;

   wvb_readout_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .hdr_empty   (hdr_empty),
      .hdr_data    (hdr_data),
      .hdr_rdreq   (hdr_rdreq),
      .wvb_rd_addr (wvb_rd_addr),
      .wvb_data    (wvb_data),
      .hdr_out     (hdr_out),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .dout_last   (dout_last),
      .busy        (busy),
      .done        (done),
      .rel_addr    (rel_addr),
      .eoe_err     (eoe_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;
   int acc_cnt = 0;
   int hq_rd = 0;
   int hq_wr = 0;
   bit ready_mode = 1'b0;
   int rc = 0;

   logic [DW-1:0] mem [4096];
   logic [HW-1:0] hq [16];
   logic [HW-1:0] last_hdr;
   logic [DW:0]   exp_q [$];
   int            rdreq_q [$];
   int            done_q [$];
   logic [AW-1:0] first_addr = '0;
   bit            prev_stall = 1'b0;
   logic [DW:0]   prev_out = '0;
   logic          exp_eoe;

   typedef struct {
      logic [AW-1:0] start;
      logic [AW-1:0] stop;
      bit            slow;
      bit            inj;
      int            n;
      logic [AW-1:0] rel;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string nm, input logic [79:0] act,
                        input logic [79:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) wvb_data <= mem[wvb_rd_addr];

   assign hdr_empty = (hq_rd == hq_wr);

   always @(posedge clk) begin
      if (hdr_rdreq && (hq_rd != hq_wr)) begin
         hdr_data <= hq[hq_rd % 16];
         hq_rd    <= hq_rd + 1;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rc++;
         dout_ready = ready_mode ? (rc % 3 == 0) : 1'b1;
      end
   end

   always @(negedge clk) begin
      logic [DW:0] ev;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (hdr_rdreq)
            rdreq_q.push_back(cyc);
         if (rdreq_q.size() > 0 && cyc == rdreq_q[$] + 2)
            first_addr = wvb_rd_addr;
         if (done) begin
            done_q.push_back(cyc);
            done_cnt++;
         end
         if (prev_stall)
            check("stall_stable", {dout_valid, dout_last, dout},
                  {1'b1, prev_out});
         if (dout_valid && dout_ready) begin
            acc_cnt++;
            check("sample_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               ev = exp_q.pop_front();
               check("sample", {dout_last, dout}, ev);
            end
         end
         prev_stall = dout_valid && !dout_ready;
         prev_out   = {dout_last, dout};
      end
   end

   task automatic push_hdr(input logic [AW-1:0] s, input logic [AW-1:0] e,
                           input bit inj, input bit expect_run);
      logic [AW-1:0] a;
      logic [AW-1:0] inj_a;
      a     = s;
      inj_a = AW'(s + 2);
      for (int k = 0; k < 4096; k++) begin
         mem[a][0] = (a == e) || (inj && a == inj_a);
         if (expect_run)
            exp_q.push_back({a == e, mem[a]});
         if (a == e)
            break;
         a = a + 1'b1;
      end
      last_hdr = {56'h5A_0000_0000_00C3 ^ 56'(hq_wr), e, s};
      hq[hq_wr % 16] = last_hdr;
      hq_wr++;
   endtask

   task automatic wait_done(input int target, input string nm);
      int k;
      k = 0;
      while (done_cnt < target && k < 400) begin
         @(posedge clk);
         k++;
      end
      check(nm, done_cnt, target);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [HW-1:0] h;
      int base;
      int k;
      rst_n = 1'b0;
      en    = 1'b0;
      for (int i = 0; i < 4096; i++)
         mem[i] = {12'(i), 9'(i * 37), 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", {hdr_rdreq, dout_valid, dout_last, busy, done,
                         eoe_err}, 6'b0);
      check("rst_addr", wvb_rd_addr, 0);
      check("rst_hdr_out", hdr_out, 0);
      check("rst_dout", dout, 0);
      check("rst_rel", rel_addr, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      vecs[0] = '{start: 12'h010, stop: 12'h013, slow: 0, inj: 0,
                  n: 4, rel: 12'h014};
      vecs[1] = '{start: 12'hFFE, stop: 12'h001, slow: 0, inj: 0,
                  n: 4, rel: 12'h002};
      vecs[2] = '{start: 12'h100, stop: 12'h100, slow: 0, inj: 0,
                  n: 1, rel: 12'h101};
      vecs[3] = '{start: 12'h200, stop: 12'h207, slow: 1, inj: 0,
                  n: 8, rel: 12'h208};
      vecs[4] = '{start: 12'h300, stop: 12'h305, slow: 0, inj: 1,
                  n: 6, rel: 12'h306};
      exp_eoe = 1'b0;
      en      = 1'b1;

      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         ready_mode = vecs[i].slow;
         acc_cnt    = 0;
         base       = done_cnt;
         push_hdr(vecs[i].start, vecs[i].stop, vecs[i].inj, 1'b1);
         h = last_hdr;
         wait_done(base + 1, "done_timeout");
         repeat (3) @(posedge clk);
         @(negedge clk);
         check("done_once", done_cnt, base + 1);
         check("rel_addr", rel_addr, vecs[i].rel);
         check("n_samples", acc_cnt, vecs[i].n);
         check("hdr_out", hdr_out, h);
         check("first_addr", first_addr, vecs[i].start);
         if (!vecs[i].slow && done_q.size() > 0 && rdreq_q.size() > 0)
            check("latency", done_q[$] - rdreq_q[$], 3 + vecs[i].n);
         check("busy_idle", busy, 1'b0);
         check("sb_empty", exp_q.size(), 0);
         exp_eoe = exp_eoe | (vecs[i].inj & EOE_ON);
         check("eoe_err", eoe_err, exp_eoe);
      end

      // Two queued headers: second pop right after the first done.
      @(posedge clk);
      #1;
      ready_mode = 1'b0;
      rdreq_q.delete();
      done_q.delete();
      base = done_cnt;
      push_hdr(12'h500, 12'h502, 1'b0, 1'b1);
      push_hdr(12'h510, 12'h511, 1'b0, 1'b1);
      h = last_hdr;
      wait_done(base + 2, "b2b_timeout");
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("b2b_pops", rdreq_q.size(), 2);
      if (rdreq_q.size() >= 2 && done_q.size() >= 1)
         check("b2b_gap", rdreq_q[1], done_q[0] + 1);
      check("b2b_hdr", hdr_out, h);
      check("b2b_rel", rel_addr, 12'h512);
      check("eoe_sticky", eoe_err, exp_eoe);

      // en dropped mid-event: event completes, then no further pops.
      @(posedge clk);
      #1;
      ready_mode = 1'b1;
      acc_cnt    = 0;
      base       = done_cnt;
      push_hdr(12'h600, 12'h607, 1'b0, 1'b1);
      k = 0;
      while (!busy && k < 50) begin
         @(posedge clk);
         k++;
      end
      #1 en = 1'b0;
      wait_done(base + 1, "en_low_timeout");
      @(negedge clk);
      check("en_low_samples", acc_cnt, 8);
      rdreq_q.delete();
      push_hdr(12'h620, 12'h621, 1'b0, 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("en0_no_pop", rdreq_q.size(), 0);
      check("en0_busy", busy, 1'b0);
      hq_wr = hq_rd;

      // Reset in the middle of an event aborts it at once.
      @(posedge clk);
      #1;
      en = 1'b1;
      push_hdr(12'h700, 12'h70F, 1'b0, 1'b1);
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("busy_mid", busy, 1'b1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("arst_ctrl", {hdr_rdreq, dout_valid, dout_last, busy, done,
                          eoe_err}, 6'b0);
      check("arst_addr", wvb_rd_addr, 0);
      check("arst_hdr_out", hdr_out, 0);
      check("arst_dout", dout, 0);
      check("arst_rel", rel_addr, 0);
      hq_wr = hq_rd;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_eoe = 1'b0;

      @(posedge clk);
      #1;
      ready_mode = 1'b0;
      acc_cnt    = 0;
      base       = done_cnt;
      push_hdr(12'h010, 12'h013, 1'b0, 1'b1);
      wait_done(base + 1, "recover_timeout");
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("recover_rel", rel_addr, 12'h014);
      check("recover_samples", acc_cnt, 4);
      check("recover_eoe", eoe_err, exp_eoe);
      check("recover_sb", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
